// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Return-stack support is selected by PC_SEQUENCER_RET_STACK_EN.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam int                          PC_WIDTH_DEFAULT      = 12;
  localparam logic [PC_WIDTH_DEFAULT-1:0] PC_RESET_ADDR_DEFAULT = 12'h000;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack; used by pc_sequencer when PC_SEQUENCER_RET_STACK_EN is defined.
// Only the pointer is reset; entry contents are don't-care until pushed.
module pc_ret_stack
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] top
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    sp_reg, sp_next;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_idx, rd_idx;

  assign full   = (sp_reg == PW'(DEPTH));
  assign empty  = (sp_reg == '0);
  assign wr_idx = sp_reg[AW-1:0];
  assign rd_idx = AW'(sp_reg - PW'(1));
  assign top    = mem_reg[rd_idx];

  always_comb begin
    sp_next = sp_reg;
    if (push && !full) begin
      sp_next = sp_reg + PW'(1);
    end else if (pop && !empty) begin
      sp_next = sp_reg - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_reg <= '0;
    end else begin
      sp_reg <= sp_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_reg[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with IDLE/RUN/HALT control and jump/call/ret.
// Define PC_SEQUENCER_RET_STACK_EN to build the return stack; otherwise call acts as jump and ret is ignored.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_ADDR  = WIDTH'(PC_RESET_ADDR_DEFAULT),
  parameter int               STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             stall,
  input  logic             halt,
  input  logic             jump,
  input  logic [WIDTH-1:0] target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] seq_addr,
  output logic             running,
  output logic             fault
);

  pc_state_e        state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic             fault_reg, fault_next;

  assign pc       = pc_reg;
  assign seq_addr = pc_reg + WIDTH'(1);
  assign running  = (state_reg == ST_RUN);
  assign fault    = fault_reg;

`ifdef PC_SEQUENCER_RET_STACK_EN
  logic             stk_push, stk_pop, stk_full, stk_empty;
  logic [WIDTH-1:0] stk_top;

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (seq_addr),
    .full      (stk_full),
    .empty     (stk_empty),
    .top       (stk_top)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{ret, 1'(STACK_DEPTH)};
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    fault_next = fault_reg;
`ifdef PC_SEQUENCER_RET_STACK_EN
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (enable) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (enable) begin
          // halt still lets this cycle's advance complete
          if (halt) state_next = ST_HALT;
          if (!stall) begin
`ifdef PC_SEQUENCER_RET_STACK_EN
            if (ret) begin
              if (stk_empty) begin
                fault_next = 1'b1;
                state_next = ST_HALT;
              end else begin
                pc_next = stk_top;
                stk_pop = 1'b1;
              end
            end else if (call) begin
              if (stk_full) begin
                fault_next = 1'b1;
                state_next = ST_HALT;
              end else begin
                pc_next  = target;
                stk_push = 1'b1;
              end
            end else if (jump) begin
              pc_next = target;
            end else begin
              pc_next = seq_addr;
            end
`else
            if (call || jump) begin
              pc_next = target;
            end else begin
              pc_next = seq_addr;
            end
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_ADDR;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; stack-specific expectations follow PC_SEQUENCER_RET_STACK_EN.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable, stall, halt, jump, call, ret;
  logic [11:0] target;
  logic [11:0] pc, seq_addr;
  logic        running, fault;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .stall    (stall),
    .halt     (halt),
    .jump     (jump),
    .target   (target),
    .call     (call),
    .ret      (ret),
    .pc       (pc),
    .seq_addr (seq_addr),
    .running  (running),
    .fault    (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    $display("chk %-14s obs=%h exp=%h", tag, obs, exp);
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; stall = 1'b0; halt = 1'b0;
    jump = 1'b0; call = 1'b0; ret = 1'b0; target = 12'h000;

    // asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 12'h000);
    chk("rst_run", running, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_seq", seq_addr, 12'h001);
    tick(); tick();
    rst_n = 1'b1;

    // IDLE -> RUN, then sequential increment
    enable = 1'b1;
    chk("idle_pc", pc, 12'h000);
    chk("idle_run", running, 1'b0);
    tick();
    chk("run1_pc", pc, 12'h000);
    chk("run1_run", running, 1'b1);
    tick(); chk("run2_pc", pc, 12'h001);
    tick(); chk("run3_pc", pc, 12'h002);
    tick(); chk("run4_pc", pc, 12'h003);
    chk("run4_seq", seq_addr, 12'h004);

    // jump
    jump = 1'b1; target = 12'h0FF;
    tick(); chk("jmp_0ff", pc, 12'h0FF);
    target = 12'h3A0;
    tick(); chk("jmp_3a0", pc, 12'h3A0);
    chk("jmp_seq", seq_addr, 12'h3A1);

    // stall blocks jump; enable low freezes increment
    stall = 1'b1; target = 12'h555;
    tick(); chk("stall_pc", pc, 12'h3A0);
    stall = 1'b0; jump = 1'b0; enable = 1'b0;
    tick(); chk("frozen_pc", pc, 12'h3A0);
    chk("frozen_run", running, 1'b1);
    enable = 1'b1;

    // wrap at top of address space
    jump = 1'b1; target = 12'hFFF;
    tick(); chk("to_fff", pc, 12'hFFF);
    jump = 1'b0;
    tick(); chk("wrap_pc", pc, 12'h000);
    chk("wrap_fault", fault, 1'b0);

    // call then ret
    jump = 1'b1; target = 12'h010;
    tick(); chk("to_010", pc, 12'h010);
    jump = 1'b0; call = 1'b1; target = 12'h100;
    tick(); chk("call_pc", pc, 12'h100);
    call = 1'b0; ret = 1'b1;
    tick();
`ifdef PC_SEQUENCER_RET_STACK_EN
    chk("ret_pc", pc, 12'h011);
`else
    chk("ret_pc", pc, 12'h101);
`endif
    chk("ret_fault", fault, 1'b0);
    ret = 1'b0;

    // halt: same-cycle jump executes, then pc holds
    halt = 1'b1; jump = 1'b1; target = 12'h0AA;
    tick(); chk("halt_pc", pc, 12'h0AA);
    chk("halt_run", running, 1'b0);
    halt = 1'b0; target = 12'h0BB;
    tick(); chk("halt_hold", pc, 12'h0AA);
    jump = 1'b0;

    // ret on empty stack
    pulse_reset();
    chk("rst2_pc", pc, 12'h000);
    tick(); chk("rst2_run", running, 1'b1);
    ret = 1'b1;
    tick();
`ifdef PC_SEQUENCER_RET_STACK_EN
    chk("uflow_fault", fault, 1'b1);
    chk("uflow_run", running, 1'b0);
    chk("uflow_pc", pc, 12'h000);
`else
    chk("noret_fault", fault, 1'b0);
    chk("noret_run", running, 1'b1);
    chk("noret_pc", pc, 12'h001);
`endif
    ret = 1'b0;

`ifdef PC_SEQUENCER_RET_STACK_EN
    // call+ret together, then overflow with depth 4
    pulse_reset();
    tick();
    jump = 1'b1; target = 12'h010;
    tick(); chk("s_to_010", pc, 12'h010);
    jump = 1'b0; call = 1'b1; target = 12'h100;
    tick(); chk("s_call", pc, 12'h100);
    ret = 1'b1; target = 12'h222;
    tick(); chk("callret_pc", pc, 12'h011);
    ret = 1'b0;
    target = 12'h200; tick(); chk("nest1", pc, 12'h200);
    target = 12'h210; tick(); chk("nest2", pc, 12'h210);
    target = 12'h220; tick(); chk("nest3", pc, 12'h220);
    target = 12'h230; tick(); chk("nest4", pc, 12'h230);
    chk("nest4_fault", fault, 1'b0);
    target = 12'h240; tick();
    chk("oflow_pc", pc, 12'h230);
    chk("oflow_fault", fault, 1'b1);
    chk("oflow_run", running, 1'b0);
    call = 1'b0; jump = 1'b1; target = 12'h0CC;
    tick(); chk("oflow_hold", pc, 12'h230);
    jump = 1'b0;
`else
    // call+ret together: call acts as jump
    call = 1'b1; ret = 1'b1; target = 12'h222;
    tick(); chk("callret_pc", pc, 12'h222);
    call = 1'b0; ret = 1'b0;
`endif

    // reset pulse between edges while a call is requested
    call = 1'b1; target = 12'h300;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 12'h000);
    chk("arst_fault", fault, 1'b0);
    chk("arst_run", running, 1'b0);
    rst_n = 1'b1; call = 1'b0;
    tick(); chk("arst_idle", pc, 12'h000);
    ret = 1'b1;
    tick();
`ifdef PC_SEQUENCER_RET_STACK_EN
    chk("arst_empty", fault, 1'b1);
    chk("arst_pc2", pc, 12'h000);
`else
    chk("arst_fault2", fault, 1'b0);
    chk("arst_pc2", pc, 12'h001);
`endif
    ret = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, 12, address width of pc, target and seq_addr.
REQ-002 Parameter RESET_ADDR, 12'h000, value loaded into pc on reset.
REQ-003 Parameter STACK_DEPTH, 4, return-stack entries; used only when RET_STACK_EN is defined.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  global advance enable; low freezes all state.
REQ-007 stall  input  1  hold pc this cycle; jump/call/ret are ignored.
REQ-008 halt  input  1  request to enter HALT.
REQ-009 jump  input  1  load target into pc.
REQ-010 target  input  WIDTH  next address, driven by the upstream 2:1 address mux output.
REQ-011 call  input  1  jump and push the return address.
REQ-012 ret  input  1  pop the return address into pc.
REQ-013 pc  output  WIDTH  current program counter, registered.
REQ-014 seq_addr  output  WIDTH  pc+1 modulo 2^WIDTH, combinational; feeds data0 of the address mux.
REQ-015 running  output  1  high in RUN state.
REQ-016 fault  output  1  sticky stack overflow/underflow flag.

Function
REQ-017 FSM states: IDLE, RUN, HALT; IDLE->RUN on the first cycle with enable=1.
REQ-018 Advance cycle = RUN and enable=1 and stall=0; pc changes only on advance cycles.
REQ-019 Advance priority: ret > call > jump > increment (pc<=seq_addr).
REQ-020 jump: pc<=target, effective next edge (1-cycle latency).
REQ-021 call: push seq_addr, pc<=target.
REQ-022 ret: pc<=top of stack, pop.
REQ-023 Increment wraps 12'hFFF -> 12'h000; no flag.
REQ-024 halt=1 in RUN with enable=1 -> HALT next edge regardless of stall; the same-cycle advance still executes; in HALT, pc holds.
REQ-025 HALT is sticky; exit only via rst_n.
REQ-026 call with stack full -> fault<=1, pc and stack unchanged, state<=HALT.
REQ-027 ret with stack empty -> fault<=1, pc unchanged, state<=HALT.
REQ-028 call and ret in the same cycle: ret wins; no push.

Reset
REQ-029 rst_n low: pc<=RESET_ADDR, state<=IDLE, running=0, fault=0, stack pointer<=0, immediately and regardless of clk.
REQ-030 Reset mid-call or mid-ret discards the operation; stack contents are don't-care, and the pointer is 0.
REQ-031 rst_n deassertion is synchronised externally; the block takes no action on deassertion beyond leaving reset.

Configuration
REQ-032 Macro PC_SEQUENCER_RET_STACK_EN defined: STACK_DEPTH-entry LIFO return stack per REQ-021/022/026/027.
REQ-033 Macro undefined: no stack storage; call behaves as jump; ret ignored (treated as increment); fault tied 0.

Structure
REQ-034 Shared package holds the FSM state typedef (IDLE/RUN/HALT), the WIDTH default and the RESET_ADDR default.
REQ-035 Return stack is one sub-module, pc_ret_stack (push, pop, full, empty, top), instantiated only under the macro.

Verification
REQ-036 Reset, then enable=1 for 5 cycles -> pc sequence 000,000(IDLE),001,002,003; running=1 from cycle 2.
REQ-037 pc=0FF, jump=1, target=3A0 -> pc=3A0 next edge; seq_addr=3A1 combinationally.
REQ-038 pc=FFF, increment -> pc=000, fault=0.
REQ-039 Macro on: call target=100 at pc=010, then ret -> pc=100, then 011; 5 nested calls with depth 4 -> fault=1, HALT, pc held.
REQ-040 Macro on: ret with empty stack -> fault=1, running=0; stall=1 with jump=1 -> pc unchanged.
REQ-041 rst_n pulsed low between edges during a call -> pc=000 and fault=0 asynchronously; stack empty after release.
